// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   UART_BYTE_W : width of one UART payload byte.
//   arb_state_t : arbiter FSM state encoding, also exported on the debug port.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req [NUM_REQ-1:0] : request vector
//   ptr [IDX_W-1:0]   : highest-priority index for this pick
//   any               : at least one request is set
//   idx [IDX_W-1:0]   : first set request at or after ptr, wrapping
module rr_pick
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk outward from ptr; the first hit wins and later hits are ignored.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter/sequencer sharing one UART TX core
// among NUM_REQ byte sources.
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_req_valid/i_req_data per-requester byte offer (byte k at [8k+7:8k])
//   o_req_ready           one-hot single-cycle capture pulse to the winner
//   o_tx_start/o_tx_data  start pulse and latched byte to the UART core
//   i_tx_busy/i_tx_done   UART core status
//   o_grant_id            index of the current/last winner
//   o_busy                high in every state except IDLE
//   o_err_timeout         sticky watchdog flag (only with UART_ARB_TIMEOUT_EN)
//   o_dbg_state           current FSM state
//
// Handshake: a requester holds i_req_valid[k] with stable data until it sees
// o_req_ready[k]; the byte is captured in that same cycle. Dropping valid
// before ready is a withdrawal and is allowed.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int GAP_CYC     = 0,
  parameter  int TIMEOUT_CYC = 200000,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic                           o_tx_start,
  output logic [UART_BYTE_W-1:0]         o_tx_data,
  input  logic                           i_tx_busy,
  input  logic                           i_tx_done,
  output logic [IDX_W-1:0]               o_grant_id,
  output logic                           o_busy,
`ifdef UART_ARB_TIMEOUT_EN
  output logic                           o_err_timeout,
`endif
  output arb_state_t                     o_dbg_state
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYC < 0 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of range");
  end

  // One counter serves both the inter-frame gap and the watchdog; the two
  // never run at the same time.
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_MAX = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
`else
  localparam int CNT_MAX = GAP_CYC;
`endif
  localparam int CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  arb_state_t             state;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       ptr_next;
  logic [CNT_W-1:0]       cnt;
  logic                   pick_any;
  logic [IDX_W-1:0]       pick_idx;
  logic [UART_BYTE_W-1:0] sel_byte;
  logic                   grant_valid;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (i_req_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    sel_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (o_grant_id == IDX_W'(k)) sel_byte = i_req_data[k*UART_BYTE_W +: UART_BYTE_W];
    end
  end

  // Ready and start are decodes of the registered state gated by the
  // handshake input of the same cycle: a withdrawal in LOAD must suppress
  // ready, and start must fire in the first cycle the core reports idle.
  always_comb begin
    o_req_ready = '0;
    if (state == ST_LOAD) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        o_req_ready[k] = (o_grant_id == IDX_W'(k)) && i_req_valid[k];
      end
    end
  end

  assign grant_valid = |o_req_ready;
  assign o_tx_start  = (state == ST_START) && !i_tx_busy;
  assign o_busy      = (state != ST_IDLE);
  assign o_dbg_state = state;
  assign ptr_next    = (o_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : o_grant_id + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      o_grant_id <= '0;
      o_tx_data  <= '0;
      cnt        <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      o_err_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            o_grant_id <= pick_idx;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Pointer advances past the winner even on withdrawal so a
          // flapping requester cannot hog the head of the rotation.
          ptr <= ptr_next;
          if (grant_valid) begin
            o_tx_data <= sel_byte;
            state     <= ST_START;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_START: begin
          if (!i_tx_busy) begin
            state <= ST_WAIT_DONE;
            cnt   <= '0;
          end
        end
        ST_WAIT_DONE: begin
          if (i_tx_done) begin
            if (GAP_CYC == 0) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_GAP;
              cnt   <= '0;
            end
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            o_err_timeout <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_GAP: begin
          if (cnt == CNT_W'(GAP_CYC - 1)) state <= ST_IDLE;
          else                             cnt   <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (NUM_REQ=4, GAP_CYC=2, TIMEOUT_CYC=50).
// Directed cases for latency, withdrawal, busy core, mid-frame reset and
// (with UART_ARB_TIMEOUT_EN) the watchdog, then a fairness run and a
// randomized run against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N        = 4;
  localparam int GAP      = 2;
  localparam int TOUT     = 50;
  localparam int FAIR_LAT = 10;
  localparam int QD       = 64;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           tx_done;
  logic [1:0]     grant_id;
  logic           busy;
  arb_state_t     dbg_state;
`ifdef UART_ARB_TIMEOUT_EN
  logic           err_timeout;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYC(GAP), .TIMEOUT_CYC(TOUT)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_valid   (req_valid),
    .i_req_data    (req_data),
    .o_req_ready   (req_ready),
    .o_tx_start    (tx_start),
    .o_tx_data     (tx_data),
    .i_tx_busy     (tx_busy),
    .i_tx_done     (tx_done),
    .o_grant_id    (grant_id),
    .o_busy        (busy),
`ifdef UART_ARB_TIMEOUT_EN
    .o_err_timeout (err_timeout),
`endif
    .o_dbg_state   (dbg_state)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]   req_buf [N][QD];
  int           req_head [N];
  int           req_tail [N];
  logic [7:0]   exp_q[$];
  int           grant_log[$];
  int           ready_log[$];
  int           mptr, core_left, last_done, injected;
  bit           have_done, pending_start, prev_ready, lat_random, inject_en;
  logic [N-1:0] prev_valid;

  // Round-robin rule: first valid index at/after the pointer, wrapping.
  function automatic int pick_model(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic eng_clear();
    for (int k = 0; k < N; k++) begin
      req_head[k] = 0;
      req_tail[k] = 0;
    end
    exp_q.delete();
    grant_log.delete();
    ready_log.delete();
    mptr = 0; core_left = 0; last_done = 0; injected = 0;
    have_done = 0; pending_start = 0; prev_ready = 0; prev_valid = '0;
  endtask

  task automatic push_byte(input int k, input logic [7:0] b);
    if (req_tail[k] < QD) begin
      req_buf[k][req_tail[k]] = b;
      req_tail[k]++;
    end
  endtask

  function automatic bit model_empty();
    for (int k = 0; k < N; k++) if (req_head[k] < req_tail[k]) return 0;
    return (exp_q.size() == 0) && (core_left == 0) && !pending_start;
  endfunction

  // One clock: requesters and UART core model drive, then outputs are checked.
  task automatic eng_cycle();
    logic [N-1:0] rdy;
    logic         busy_drv;
    int           w;
    tick();
    if (inject_en && injected < 24 && $urandom_range(0, 7) == 0) begin
      push_byte($urandom_range(0, N - 1), 8'($urandom));
      injected++;
    end
    for (int k = 0; k < N; k++) begin
      req_valid[k] = (req_head[k] < req_tail[k]);
      req_data[8*k +: 8] = req_valid[k] ? req_buf[k][req_head[k]] : 8'($urandom);
    end
    // Core: busy for the frame, done pulse in its last cycle with busy low.
    if (core_left > 1) begin
      tx_busy = 1'b1; tx_done = 1'b0;
    end else if (core_left == 1) begin
      tx_busy = 1'b0; tx_done = 1'b1;
      have_done = 1; last_done = cyc;
    end else begin
      tx_busy = 1'b0; tx_done = 1'b0;
    end
    if (core_left > 0) core_left--;
    busy_drv = tx_busy;
    #3;
    rdy = req_ready;
    // A start is due in the first core-idle cycle after a capture.
    if (tx_start || (pending_start && !busy_drv)) begin
      check_eq("start_due", tx_start, pending_start && !busy_drv);
      if (tx_start && exp_q.size() > 0) begin
        check_eq("tx_data", tx_data, exp_q.pop_front());
        core_left = lat_random ? $urandom_range(1, 8) : FAIR_LAT;
      end
      pending_start = 0;
    end
    if (rdy != '0) begin
      w = pick_model(prev_valid, mptr);
      check_eq("ready_onehot", $onehot(rdy), 1);
      check_eq("ready_single_cycle", prev_ready, 0);
      check_eq("ready_winner", rdy, (w < 0) ? 0 : (1 << w));
      if (w >= 0) begin
        check_eq("grant_id", grant_id, w);
        if (have_done) check_eq("gap_spacing", (cyc - last_done) >= GAP + 2, 1);
        exp_q.push_back(req_buf[w][req_head[w]]);
        req_head[w]++;
        grant_log.push_back(w);
        ready_log.push_back(cyc);
        mptr = (w + 1) % N;
        pending_start = 1;
      end
    end
    prev_ready = (rdy != '0);
    prev_valid = req_valid;
  endtask

  task automatic eng_drain(input int max_cyc);
    bit drained;
    drained = 0;
    for (int n = 0; n < max_cyc; n++) begin
      eng_cycle();
      if (model_empty()) begin
        drained = 1;
        break;
      end
    end
    check_eq("drain", drained, 1);
    repeat (GAP + 3) eng_cycle();
    check_eq("drain_idle", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  int fair_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
    inject_en = 0; lat_random = 0;
    eng_clear();

    // Reset state.
    tick(); tick(); #3;
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_start", tx_start, 0);
    check_eq("rst_data", tx_data, 0);
    check_eq("rst_grant", grant_id, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_state", dbg_state, ST_IDLE);
`ifdef UART_ARB_TIMEOUT_EN
    check_eq("rst_err", err_timeout, 0);
`endif
    rst_n = 1'b1;

    // Single request: ready in cycle 1, start in cycle 2.
    tick(); req_valid = 4'b0100; req_data = '0; req_data[23:16] = 8'h41; #3;
    check_eq("single_c0_ready", req_ready, 0);
    tick(); #3;
    check_eq("single_ready", req_ready, 4'b0100);
    check_eq("single_grant", grant_id, 2);
    check_eq("single_c1_start", tx_start, 0);
    tick(); req_valid = '0; #3;
    check_eq("single_start", tx_start, 1);
    check_eq("single_data", tx_data, 8'h41);
    tick(); tx_busy = 1'b1; #3;
    check_eq("single_start_pulse", tx_start, 0);
    check_eq("single_busy", busy, 1);
    repeat (3) tick();
    tick(); tx_busy = 1'b0; tx_done = 1'b1; #3;
    tick(); tx_done = 1'b0; #3;
    check_eq("single_gap_busy", busy, 1);
    check_eq("single_data_hold", tx_data, 8'h41);
    tick(); tick(); #3;
    check_eq("single_idle", busy, 0);
    check_eq("single_idle_state", dbg_state, ST_IDLE);

    // Withdrawal in LOAD: no ready, back to IDLE, pointer moves to 2.
    do_reset();
    tick(); req_valid = 4'b0010; req_data[15:8] = 8'h77; #3;
    tick(); req_valid = '0; #3;
    check_eq("wd_ready", req_ready, 0);
    tick(); #3;
    check_eq("wd_start", tx_start, 0);
    check_eq("wd_busy", busy, 0);
    check_eq("wd_state", dbg_state, ST_IDLE);
    tick(); req_valid = 4'b0110; #3;
    tick(); #3;
    check_eq("wd_pointer", req_ready, 4'b0100);
    check_eq("wd_grant", grant_id, 2);
    tick(); req_valid = '0; #3;

    // Busy core defers start; then reset mid WAIT_DONE.
    do_reset();
    tick(); req_valid = 4'b0010; req_data[15:8] = 8'h5A; #3;
    tick(); tx_busy = 1'b1; #3;
    check_eq("busy_ready", req_ready, 4'b0010);
    for (int i = 2; i <= 5; i++) begin
      tick(); req_valid = '0; #3;
      check_eq("busy_hold_start", tx_start, 0);
    end
    tick(); tx_busy = 1'b0; #3;
    check_eq("busy_release_start", tx_start, 1);
    check_eq("busy_data", tx_data, 8'h5A);
    tick(); tx_busy = 1'b1; #3;
    check_eq("busy_wait_busy", busy, 1);
    tick(); rst_n = 1'b0; #3;
    tick(); rst_n = 1'b1; tx_busy = 1'b0; #3;
    check_eq("mid_rst_ready", req_ready, 0);
    check_eq("mid_rst_start", tx_start, 0);
    check_eq("mid_rst_data", tx_data, 0);
    check_eq("mid_rst_grant", grant_id, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_state", dbg_state, ST_IDLE);
    tick(); tx_done = 1'b1; #3;
    tick(); tx_done = 1'b0; #3;
    check_eq("late_done_busy", busy, 0);
    check_eq("late_done_start", tx_start, 0);
    tick(); req_valid = 4'b0110; #3;
    tick(); #3;
    check_eq("rst_pointer", req_ready, 4'b0010);
    tick(); req_valid = '0; #3;

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog: no done for TOUT cycles of WAIT_DONE.
    do_reset();
    tick(); req_valid = 4'b0001; req_data[7:0] = 8'hC3; #3;
    tick(); #3;
    tick(); req_valid = '0; #3;
    check_eq("to_start", tx_start, 1);
    for (int i = 3; i <= 2 + TOUT; i++) begin
      tick(); #3;
    end
    check_eq("to_err_before", err_timeout, 0);
    check_eq("to_busy_before", busy, 1);
    tick(); #3;
    check_eq("to_err", err_timeout, 1);
    check_eq("to_state", dbg_state, ST_IDLE);
    tick(); tx_done = 1'b1; #3;
    tick(); tx_done = 1'b0; #3;
    check_eq("to_err_sticky", err_timeout, 1);
    check_eq("to_late_done", busy, 0);
`endif

    // Fairness: all four valid continuously, done 10 cycles after start.
    do_reset();
    eng_clear();
    lat_random = 0;
    for (int k = 0; k < N; k++) begin
      push_byte(k, 8'(8'hA0 + 16 * k));
      push_byte(k, 8'(8'hA1 + 16 * k));
    end
    eng_drain(400);
    check_eq("fair_count", grant_log.size(), 2 * N);
    for (int i = 0; i < 5; i++) check_eq("fair_order", grant_log[i], fair_exp[i]);
    for (int i = 1; i < ready_log.size(); i++)
      check_eq("fair_spacing", ready_log[i] - ready_log[i-1], FAIR_LAT + GAP + 3);

    // Randomized traffic with random frame lengths.
    do_reset();
    eng_clear();
    lat_random = 1;
    for (int k = 0; k < N; k++) begin
      repeat ($urandom_range(0, 3)) push_byte(k, 8'($urandom));
    end
    inject_en = 1;
    repeat (300) eng_cycle();
    inject_en = 0;
    eng_drain(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
